// File: rtl/dsm_dac_ctrl.sv
// Sample scheduler and run controller for the delta-sigma DAC modulator.
// Paces a valid/ready sample source to one sample per oversampling period and sequences start/stop/flush.
module dsm_dac_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int OSR_WIDTH      = 8,
  parameter int FLUSH_SAMPLES  = 4,
  parameter int UNDERFLOW_ZERO = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [OSR_WIDTH-1:0]  i_osr,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_dac_en,
  output logic [DATA_WIDTH-1:0] o_dac_data,
  output logic                  o_sample_tick,
  output logic                  o_busy,
  output logic                  o_underflow
);

  localparam int FLUSH_W = (FLUSH_SAMPLES > 0) ? $clog2(FLUSH_SAMPLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [OSR_WIDTH-1:0] cnt;
  logic [OSR_WIDTH-1:0] osr_q;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 tick;
  logic                 start_ok;

  assign tick          = (state != IDLE) && (cnt == osr_q);
  assign start_ok      = i_start && !i_stop;
  assign o_sample_tick = tick;
  assign o_s_ready     = tick && (state == RUN);
  assign o_busy        = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (i_stop) state_nxt = (FLUSH_SAMPLES > 0) ? FLUSH : IDLE;
      FLUSH:   if (tick && (flush_cnt == FLUSH_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A stop overrides any sample loaded by a coincident tick, so the modulator sees zero next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= '0;
      osr_q       <= '0;
      flush_cnt   <= '0;
      o_dac_data  <= '0;
      o_dac_en    <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_dac_en <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            osr_q       <= i_osr;
            cnt         <= '0;
            o_dac_data  <= '0;
            o_underflow <= 1'b0;
          end
        end
        RUN: begin
          cnt <= tick ? '0 : cnt + OSR_WIDTH'(1);
          if (tick) begin
            if (i_s_valid) begin
              o_dac_data <= i_s_data;
            end else begin
              o_underflow <= 1'b1;
              if (UNDERFLOW_ZERO != 0) o_dac_data <= '0;
            end
          end
          if (i_stop) begin
            o_dac_data <= '0;
            flush_cnt  <= FLUSH_W'(FLUSH_SAMPLES);
          end
        end
        FLUSH: begin
          cnt <= tick ? '0 : cnt + OSR_WIDTH'(1);
          if (tick) flush_cnt <= flush_cnt - FLUSH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_dac_ctrl.sv
// Self-checking bench for dsm_dac_ctrl: two instances (flush/zero-on-underflow and no-flush/hold)
// share stimulus and are compared every cycle against a countdown-based reference model.
module tb_dsm_dac_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  osr;
  logic        s_valid;
  logic [15:0] s_data;

  logic        a_ready, a_en, a_tick, a_busy, a_uf;
  logic [15:0] a_data;
  logic        b_ready, b_en, b_tick, b_busy, b_uf;
  logic [15:0] b_data;

  int vectors;
  int miscompares;

  // Reference model state, index 0 = instance a, 1 = instance b
  int          flush_len [2] = '{2, 0};
  bit          zero_uf   [2] = '{1'b1, 1'b0};
  int          m_mode    [2];
  int          m_wait    [2];
  int          m_period  [2];
  int          m_left    [2];
  logic [15:0] m_data    [2];
  bit          m_en      [2];
  bit          m_uf      [2];

  dsm_dac_ctrl #(
    .DATA_WIDTH(16), .OSR_WIDTH(8), .FLUSH_SAMPLES(2), .UNDERFLOW_ZERO(1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_osr(osr),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(a_ready), .o_dac_en(a_en),
    .o_dac_data(a_data), .o_sample_tick(a_tick), .o_busy(a_busy), .o_underflow(a_uf)
  );

  dsm_dac_ctrl #(
    .DATA_WIDTH(16), .OSR_WIDTH(8), .FLUSH_SAMPLES(0), .UNDERFLOW_ZERO(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_osr(osr),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(b_ready), .o_dac_en(b_en),
    .o_dac_data(b_data), .o_sample_tick(b_tick), .o_busy(b_busy), .o_underflow(b_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_wait[k] = 0; m_period[k] = 0; m_left[k] = 0;
      m_data[k] = '0; m_en[k] = 1'b0; m_uf[k] = 1'b0;
    end
  endfunction

  // A sample boundary happens when the clocks remaining in the current period run out.
  function automatic bit model_tick(int k);
    return (m_mode[k] != 0) && (m_wait[k] == 0);
  endfunction

  function automatic bit model_ready(int k);
    return model_tick(k) && (m_mode[k] == 1);
  endfunction

  function automatic void model_step(int k, bit st, bit sp, int period, bit valid, logic [15:0] data);
    bit boundary;
    int mode_now;
    boundary = model_tick(k);
    mode_now = m_mode[k];
    if (mode_now != 0) m_wait[k] = boundary ? m_period[k] : m_wait[k] - 1;
    if (mode_now == 0) begin
      if (st && !sp) begin
        m_mode[k] = 1; m_period[k] = period; m_wait[k] = period;
        m_data[k] = '0; m_uf[k] = 1'b0;
      end
    end else if (mode_now == 1) begin
      if (boundary) begin
        if (valid) m_data[k] = data;
        else begin
          m_uf[k] = 1'b1;
          if (zero_uf[k]) m_data[k] = '0;
        end
      end
      if (sp) begin
        m_data[k] = '0;
        m_left[k] = flush_len[k];
        m_mode[k] = (flush_len[k] > 0) ? 2 : 0;
      end
    end else if (boundary) begin
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) m_mode[k] = 0;
    end
    m_en[k] = (m_mode[k] != 0);
  endfunction

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    compare("a.dac_data", 32'(a_data), 32'(m_data[0]));
    compare("a.dac_en", 32'(a_en), 32'(m_en[0]));
    compare("a.tick", 32'(a_tick), 32'(model_tick(0)));
    compare("a.ready", 32'(a_ready), 32'(model_ready(0)));
    compare("a.busy", 32'(a_busy), 32'(m_mode[0] != 0));
    compare("a.underflow", 32'(a_uf), 32'(m_uf[0]));
    compare("b.dac_data", 32'(b_data), 32'(m_data[1]));
    compare("b.dac_en", 32'(b_en), 32'(m_en[1]));
    compare("b.tick", 32'(b_tick), 32'(model_tick(1)));
    compare("b.ready", 32'(b_ready), 32'(model_ready(1)));
    compare("b.busy", 32'(b_busy), 32'(m_mode[1] != 0));
    compare("b.underflow", 32'(b_uf), 32'(m_uf[1]));
  endtask

  // Called at posedge+1: drive, check the current cycle, advance the model across the next edge.
  task automatic applyStimulus(input bit st, input bit sp, input int period, input bit valid,
                               input logic [15:0] data);
    start   = st;
    stop    = sp;
    osr     = 8'(period);
    s_valid = valid;
    s_data  = data;
    checkOutput();
    for (int k = 0; k < 2; k++) model_step(k, st, sp, period, valid, data);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] seq3 [3];
    int idx;
    int nticks;
    bit acc;
    vectors     = 0;
    miscompares = 0;
    seq3 = '{16'h0100, 16'h0200, 16'h0300};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; osr = '0; s_valid = 1'b0; s_data = '0;
    model_reset();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] osr=3 continuous stream");
    applyStimulus(1'b1, 1'b0, 3, 1'b1, seq3[0]);
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      acc = model_ready(0);
      applyStimulus(1'b0, 1'b0, 3, 1'b1, seq3[idx]);
      if (acc && idx < 2) idx++;
    end
    applyStimulus(1'b0, 1'b1, 3, 1'b1, seq3[idx]);
    idleCycles(12);

    $display("[TB] osr=3 underflow on second sample");
    applyStimulus(1'b1, 1'b0, 3, 1'b1, 16'h0A00);
    nticks = 0;
    for (int i = 0; i < 16; i++) begin
      acc = model_tick(0);
      applyStimulus(1'b0, 1'b0, 3, nticks != 1, 16'(16'h0A00 + nticks));
      if (acc) nticks++;
    end
    applyStimulus(1'b0, 1'b1, 3, 1'b1, 16'h0BEE);
    idleCycles(12);

    $display("[TB] osr=1 stop and flush, start during flush");
    applyStimulus(1'b1, 1'b0, 1, 1'b1, 16'h0011);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1, 1'b1, 16'(16'h0020 + i));
    applyStimulus(1'b0, 1'b1, 1, 1'b1, 16'h0033);
    applyStimulus(1'b1, 1'b0, 5, 1'b1, 16'h0044);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1, 1'b1, 16'h0055);
    applyStimulus(1'b0, 1'b1, 1, 1'b0, 16'h0);
    idleCycles(8);

    $display("[TB] start and stop together in IDLE");
    applyStimulus(1'b1, 1'b1, 2, 1'b1, 16'h0066);
    idleCycles(3);

    $display("[TB] osr=0 back-to-back stream");
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 16'd1);
    idx = 1;
    for (int i = 0; i < 6; i++) begin
      acc = model_ready(0);
      applyStimulus(1'b0, 1'b0, 0, idx <= 4, 16'(idx));
      if (acc && idx <= 4) idx++;
    end
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 16'h0);
    idleCycles(4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 4), $urandom_range(0, 3) != 0, 16'($urandom));
    end
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 16'h0);
    idleCycles(16);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b1, 1'b0, 2, 1'b1, 16'h1234);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 2, 1'b1, 16'h1234);
    checkOutput();
    compare("a.data_before_reset", 32'(a_data), 32'h1234);
    start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(2);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
